// File: rtl/uart_frame_tx.sv
// Serializer for 12-bit UART frames: shifts frame[11] first, each bit held CLKS_PER_BIT clocks.
// Optional build macro UART_TX_PARITY_CHECK_EN drops frames whose parity bit disagrees with even parity of the data.
module uart_frame_tx #(
    parameter int   CLKS_PER_BIT = 16,
    parameter int   FRAME_W      = 12,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic [FRAME_W-1:0] frame,
    output logic               tx,
    output logic               busy,
    output logic               done,
    output logic               parity_err
);

    localparam int CNT_RAW = $clog2(CLKS_PER_BIT + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam int IDX_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [FRAME_W-1:0] shift_reg;
    logic               frame_ok;

    assign frame_ready = (state == IDLE);

`ifdef UART_TX_PARITY_CHECK_EN
    assign frame_ok = (frame[2] == ^frame[10:3]);
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign frame_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Accept in IDLE, then walk bit_idx down from the top bit once per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= IDX_TOP;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef UART_TX_PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (frame_valid) begin
                        if (frame_ok) begin
                            shift_reg <= frame;
                            tx        <= frame[FRAME_W-1];
                            baud_cnt  <= '0;
                            bit_idx   <= IDX_TOP;
                            busy      <= 1'b1;
                            state     <= SHIFT;
                        end else begin
`ifdef UART_TX_PARITY_CHECK_EN
                            parity_err_q <= 1'b1;
`endif
                        end
                    end
                end
                SHIFT: begin
                    if (baud_cnt == BAUD_MAX) begin
                        baud_cnt <= '0;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - IDX_ONE;
                            tx      <= shift_reg[bit_idx - IDX_ONE];
                        end else begin
                            tx    <= IDLE_LEVEL;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: cycle-level reference model plus directed literal checks and random traffic.
module tb_uart_frame_tx;

    localparam int CPB   = 4;
    localparam int NBITS = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_valid;
    logic [11:0] frame;
    logic        frame_ready;
    logic        tx;
    logic        busy;
    logic        done;
    logic        parity_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame       (frame),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .parity_err  (parity_err)
    );

    // Reference model: elapsed cycles since accept, or -1 when idle.
    int          m_elapsed = -1;
    logic [11:0] m_frame   = '0;
    bit          m_done    = 1'b0;
    bit          m_perr    = 1'b0;
    int          cyc       = 0;
    bit          chk_en    = 1'b0;
    int          busy_cnt  = 0;
    int          done_cnt  = 0;

    function automatic bit parityOk(input logic [11:0] f);
        return f[2] == ^f[10:3];
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        m_perr = 1'b0;
        if (rst) begin
            m_elapsed = -1;
        end else if (m_elapsed >= 0) begin
            m_elapsed++;
            if (m_elapsed == NBITS * CPB) begin
                m_elapsed = -1;
                m_done    = 1'b1;
            end
        end else if (frame_valid) begin
`ifdef UART_TX_PARITY_CHECK_EN
            if (!parityOk(frame)) begin
                m_perr = 1'b1;
            end else begin
                m_frame   = frame;
                m_elapsed = 0;
            end
`else
            m_frame   = frame;
            m_elapsed = 0;
`endif
        end
    end

    function automatic logic expTx();
        if (m_elapsed < 0) return 1'b1;
        return m_frame[11 - m_elapsed / CPB];
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model, sampled 1ns after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            checkOutput("tx",          tx,          expTx());
            checkOutput("busy",        busy,        m_elapsed >= 0);
            checkOutput("frame_ready", frame_ready, m_elapsed < 0);
            checkOutput("done",        done,        m_done);
            checkOutput("parity_err",  parity_err,  m_perr);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic applyStimulus(input logic v, input logic [11:0] f);
        @(negedge clk);
        frame_valid = v;
        frame       = f;
    endtask

    task automatic waitDone(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                dcyc = cyc;
                return;
            end
            @(negedge clk);
        end
        bad++;
        $display("[TB] FAIL done_timeout cycle %0d: got no done want done within %0d", cyc, limit);
    endtask

    function automatic logic [11:0] goodFrame();
        logic [11:0] f;
        f    = 12'($urandom);
        f[2] = ^f[10:3];
        return f;
    endfunction

    initial begin
        int          acc;
        int          d1;
        int          d2;
        int          d0;
        int          exp_bits[12] = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
        logic [11:0] f;

        rst         = 1'b1;
        frame_valid = 1'b1;
        frame       = 12'hD28;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_tx",    tx,          1'b1);
        checkOutput("rst_ready", frame_ready, 1'b1);
        checkOutput("rst_busy",  busy,        1'b0);
        checkOutput("rst_done",  done,        1'b0);
        rst         = 1'b0;
        frame_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame D28 with mid-bit literal sampling.
        @(negedge clk);
        frame_valid = 1'b1;
        frame       = 12'hD28;
        busy_cnt    = 0;
        acc         = cyc + 1;
        @(negedge clk);
        frame_valid = 1'b0;
        for (int k = 0; k < NBITS; k++) begin
            @(negedge clk);
            checkOutput($sformatf("d28_bit%0d", k), tx, exp_bits[k][0]);
            repeat (CPB - 1) @(negedge clk);
        end
        waitDone(200, d1);
        checkInt("d28_latency", d1 - acc, 48);
        checkInt("d28_busy_len", busy_cnt, 48);
        repeat (3) @(negedge clk);

        // Back-to-back with frame_valid held high.
        applyStimulus(1'b1, 12'hD28);
        applyStimulus(1'b1, 12'h80C);
        waitDone(200, d1);
        checkOutput("b2b_gap_tx",    tx,          1'b1);
        checkOutput("b2b_gap_ready", frame_ready, 1'b1);
        @(negedge clk);
        frame_valid = 1'b0;
        checkOutput("b2b_second_busy", busy, 1'b1);
        @(negedge clk);
        waitDone(200, d2);
        checkInt("b2b_done_spacing", d2 - d1, 49);
        repeat (3) @(negedge clk);

        // Upstream changes during SHIFT must not disturb the latched frame.
        applyStimulus(1'b1, goodFrame());
        repeat (2 * CPB) @(negedge clk);
        frame = 12'hFFF;
        checkOutput("hold_ready_low", frame_ready, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        checkOutput("hold_ready_low2", frame_ready, 1'b0);
        frame_valid = 1'b0;
        waitDone(200, d1);
        repeat (3) @(negedge clk);

        // Reset while bit_idx is 6.
        applyStimulus(1'b1, 12'hD28);
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (5 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        d0  = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_tx",    tx,          1'b1);
        checkOutput("mid_rst_ready", frame_ready, 1'b1);
        checkOutput("mid_rst_busy",  busy,        1'b0);
        repeat (60) @(negedge clk);
        checkInt("mid_rst_no_done", done_cnt, d0);
        applyStimulus(1'b1, goodFrame());
        applyStimulus(1'b0, 12'h000);
        waitDone(200, d1);
        repeat (3) @(negedge clk);

        // Frame with wrong parity bit.
        applyStimulus(1'b1, 12'h808);
        @(negedge clk);
        frame_valid = 1'b0;
`ifdef UART_TX_PARITY_CHECK_EN
        checkOutput("perr_pulse", parity_err, 1'b1);
        checkOutput("perr_busy",  busy,       1'b0);
        checkOutput("perr_tx",    tx,         1'b1);
        @(negedge clk);
        checkOutput("perr_once", parity_err, 1'b0);
`else
        checkOutput("noperr_flag", parity_err, 1'b0);
        checkOutput("noperr_busy", busy,       1'b1);
        waitDone(200, d1);
`endif
        repeat (3) @(negedge clk);

        // Random traffic, occasional reset.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            frame_valid = ($urandom_range(0, 3) != 0);
            frame       = ($urandom_range(0, 1) == 0) ? goodFrame() : 12'($urandom);
            rst         = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst         = 1'b0;
        frame_valid = 1'b0;
        repeat (NBITS * CPB + 5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
